// File: rtl/core_result_sink.sv
// Result sink for the hashing core: buffers block-found events in a FWFT FIFO,
// rolls the header version on nonce exhaustion and runs a stale-work watchdog.
module core_result_sink #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned STALE_LIMIT = 600
) (
  input  logic                       sec_tick_clk,
  input  logic                       rst,
  input  logic [2:0]                 blk_fnd,
  input  logic [31:0]                crnt_nonce,
  input  logic [31:0]                cr_tme,
  input  logic                       inc_vrn_flg,
  input  logic [31:0]                version_in,
  input  logic                       work_ld,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [1:0]                 rd_core,
  output logic [31:0]                rd_nonce,
  output logic [31:0]                rd_time,
  output logic [31:0]                rd_version,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic                       ovf,
  output logic [31:0]                version_out,
  output logic                       roll_req,
  output logic                       stale
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STALE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ROLL    = 2'd1,
    S_WAIT_LD = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  core;
    logic [31:0] nonce;
    logic [31:0] tme;
    logic [31:0] version;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    fnd_prev;
  logic          vrn_prev;
  logic          push;
  logic          roll;
  logic          pop;
  logic          full;
  logic          wr_en;
  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] stale_cnt;
  logic          unused_fnd_bit;

  assign unused_fnd_bit = blk_fnd[2];

  // Edge detection on the core's level-style flags.
  always_ff @(posedge sec_tick_clk or posedge rst) begin
    if (rst) begin
      fnd_prev <= 2'd0;
      vrn_prev <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      fnd_prev <= blk_fnd[1:0];
      vrn_prev <= inc_vrn_flg;
    end
  end

  assign push  = (blk_fnd[1:0] != 2'd0) && (blk_fnd[1:0] != fnd_prev);
  assign roll  = inc_vrn_flg && !vrn_prev;
  assign rd_vld = (count != '0);
  assign pop   = rd_vld && rd_rdy;
  assign full  = (count == CW'(DEPTH));
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);

  // NOTE: storage has no reset; the head is masked by rd_vld so stale contents never reach the port.
  always_ff @(posedge sec_tick_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{core: blk_fnd[1:0], nonce: crnt_nonce, tme: cr_tme, version: version_out};
    end
  end

  always_ff @(posedge sec_tick_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    head = '0;
    if (rd_vld) head = mem[rd_ptr];
  end

  assign rd_core    = head.core;
  assign rd_nonce   = head.nonce;
  assign rd_time    = head.tme;
  assign rd_version = head.version;
  assign fifo_cnt   = count;

  always_ff @(posedge sec_tick_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A work load always returns to IDLE unless a fresh roll arrives in IDLE the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (roll) state_nxt = S_ROLL;
      S_ROLL:    state_nxt = S_WAIT_LD;
      S_WAIT_LD: state_nxt = S_WAIT_LD;
      default:   state_nxt = S_IDLE;
    endcase
    if (work_ld) state_nxt = (state == S_IDLE && roll) ? S_ROLL : S_IDLE;
  end

  always_comb begin
    roll_req = 1'b0;
    if (state == S_WAIT_LD) roll_req = 1'b1;
  end

  always_ff @(posedge sec_tick_clk or posedge rst) begin
    if (rst)                  version_out <= 32'd0;
    else if (work_ld)         version_out <= version_in;
    else if (state == S_ROLL) version_out <= version_out + 32'd1;
  end

  always_ff @(posedge sec_tick_clk or posedge rst) begin
    if (rst)                                  stale_cnt <= '0;
    else if (work_ld)                         stale_cnt <= '0;
    else if (stale_cnt != SW'(STALE_LIMIT))   stale_cnt <= stale_cnt + SW'(1);
  end

  assign stale = (stale_cnt == SW'(STALE_LIMIT));

endmodule

// File: tb/tb_core_result_sink.sv
// Self-checking bench for core_result_sink: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_core_result_sink;

  localparam int DEPTH       = 4;
  localparam int STALE_LIMIT = 5;

  logic        sec_tick_clk = 1'b0;
  logic        rst          = 1'b1;
  logic [2:0]  blk_fnd      = '0;
  logic [31:0] crnt_nonce   = '0;
  logic [31:0] cr_tme       = '0;
  logic        inc_vrn_flg  = 1'b0;
  logic [31:0] version_in   = '0;
  logic        work_ld      = 1'b0;
  logic        rd_rdy       = 1'b0;
  logic        rd_vld;
  logic [1:0]  rd_core;
  logic [31:0] rd_nonce;
  logic [31:0] rd_time;
  logic [31:0] rd_version;
  logic [2:0]  fifo_cnt;
  logic        ovf;
  logic [31:0] version_out;
  logic        roll_req;
  logic        stale;

  core_result_sink #(.DEPTH(DEPTH), .STALE_LIMIT(STALE_LIMIT)) dut (
    .sec_tick_clk(sec_tick_clk), .rst(rst), .blk_fnd(blk_fnd),
    .crnt_nonce(crnt_nonce), .cr_tme(cr_tme), .inc_vrn_flg(inc_vrn_flg),
    .version_in(version_in), .work_ld(work_ld), .rd_rdy(rd_rdy),
    .rd_vld(rd_vld), .rd_core(rd_core), .rd_nonce(rd_nonce), .rd_time(rd_time),
    .rd_version(rd_version), .fifo_cnt(fifo_cnt), .ovf(ovf),
    .version_out(version_out), .roll_req(roll_req), .stale(stale)
  );

  always #5 sec_tick_clk = ~sec_tick_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: results held in a queue, version roll as a small phase variable.
  typedef struct packed {
    logic [1:0]  core;
    logic [31:0] nonce;
    logic [31:0] tme;
    logic [31:0] ver;
  } ent_t;

  ent_t        q[$];
  logic [1:0]  m_prev_code;
  logic        m_prev_flag;
  logic        m_ovf;
  logic [31:0] m_ver;
  int          m_phase;   // 0 idle, 1 roll due on next edge, 2 waiting for new work
  int          m_stale;

  task automatic model_reset();
    q.delete();
    m_prev_code = 2'd0;
    m_prev_flag = 1'b0;
    m_ovf       = 1'b0;
    m_ver       = 32'd0;
    m_phase     = 0;
    m_stale     = 0;
  endtask

  task automatic model_step();
    logic [1:0] code;
    bit         is_push, is_roll, is_pop;
    int         occ;
    ent_t       e;
    code    = blk_fnd[1:0];
    is_push = (code != 2'd0) && (code != m_prev_code);
    is_roll = inc_vrn_flg && !m_prev_flag;
    occ     = q.size();
    is_pop  = (occ > 0) && rd_rdy;
    e       = '{core: code, nonce: crnt_nonce, tme: cr_tme, ver: m_ver};
    if (is_pop) void'(q.pop_front());
    if (is_push) begin
      if (occ < DEPTH || is_pop) q.push_back(e);
      else m_ovf = 1'b1;
    end
    if (work_ld) begin
      m_phase = (m_phase == 0 && is_roll) ? 1 : 0;
      m_ver   = version_in;
    end else if (m_phase == 1) begin
      m_ver   = m_ver + 32'd1;
      m_phase = 2;
    end else if (m_phase == 0 && is_roll) begin
      m_phase = 1;
    end
    if (work_ld) m_stale = 0;
    else if (m_stale < STALE_LIMIT) m_stale++;
    m_prev_code = code;
    m_prev_flag = inc_vrn_flg;
  endtask

  task automatic compare_all();
    check("rd_vld", rd_vld, (q.size() > 0));
    check("fifo_cnt", fifo_cnt, q.size());
    check("ovf", ovf, m_ovf);
    check("version_out", version_out, m_ver);
    check("roll_req", roll_req, (m_phase == 2));
    check("stale", stale, (m_stale == STALE_LIMIT));
    if (q.size() > 0) begin
      check("rd_core", rd_core, q[0].core);
      check("rd_nonce", rd_nonce, q[0].nonce);
      check("rd_time", rd_time, q[0].tme);
      check("rd_version", rd_version, q[0].ver);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge sec_tick_clk);
    #1;
    compare_all();
  endtask

  // Asserted between edges; outputs must drop to reset values without a clock.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_vld"}, rd_vld, 0);
    check({tag, "_rst_cnt"}, fifo_cnt, 0);
    check({tag, "_rst_ovf"}, ovf, 0);
    check({tag, "_rst_ver"}, version_out, 0);
    check({tag, "_rst_req"}, roll_req, 0);
    check({tag, "_rst_stale"}, stale, 0);
    check({tag, "_rst_core"}, rd_core, 0);
    check({tag, "_rst_nonce"}, rd_nonce, 0);
    check({tag, "_rst_time"}, rd_time, 0);
    check({tag, "_rst_rver"}, rd_version, 0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_work(input logic [31:0] v);
    version_in = v;
    work_ld    = 1'b1;
    tick();
    work_ld    = 1'b0;
  endtask

  initial begin
    int exp_codes[4];
    model_reset();
    #12;
    do_reset("init");

    // Held code gives exactly one entry.
    blk_fnd = 3'd2; crnt_nonce = 32'h1DAC2B7C; cr_tme = 32'h495FAB29;
    repeat (5) tick();
    check("t1_cnt", fifo_cnt, 1);
    check("t1_core", rd_core, 2);
    check("t1_nonce", rd_nonce, 32'h1DAC2B7C);
    check("t1_time", rd_time, 32'h495FAB29);
    check("t1_ver", rd_version, 0);

    // Overflow with alternating codes.
    do_reset("t2");
    blk_fnd = 3'd0;
    tick();
    for (int i = 0; i < 6; i++) begin
      blk_fnd = (i % 2 == 1) ? 3'd3 : 3'd1;
      crnt_nonce = 32'h100 + i;
      tick();
    end
    blk_fnd = 3'd0;
    check("t2_cnt", fifo_cnt, 4);
    check("t2_ovf", ovf, 1);
    exp_codes = '{1, 3, 1, 3};
    rd_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_order", rd_core, exp_codes[i]);
      tick();
    end
    rd_rdy = 1'b0;
    check("t2_empty", rd_vld, 0);

    // Push and pop together while full.
    do_reset("t3");
    for (int i = 0; i < 4; i++) begin
      blk_fnd = (i % 2 == 1) ? 3'd2 : 3'd1;
      tick();
    end
    blk_fnd = 3'd3; rd_rdy = 1'b1;
    tick();
    check("t3_cnt", fifo_cnt, 4);
    check("t3_ovf", ovf, 0);
    blk_fnd = 3'd0;
    exp_codes = '{2, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      check("t3_order", rd_core, exp_codes[i]);
      tick();
    end
    rd_rdy = 1'b0;

    // Version roll and ignored second rise.
    do_reset("t4");
    pulse_work(32'h20000000);
    inc_vrn_flg = 1'b1;
    tick();
    check("t4_req_early", roll_req, 0);
    tick();
    check("t4_ver", version_out, 32'h20000001);
    check("t4_req", roll_req, 1);
    inc_vrn_flg = 1'b0;
    tick();
    inc_vrn_flg = 1'b1;
    tick();
    tick();
    check("t4_ignored", version_out, 32'h20000001);
    pulse_work(32'h20000001);
    check("t4_req_clr", roll_req, 0);

    // Version wrap, then work load and roll in the same cycle.
    inc_vrn_flg = 1'b0;
    do_reset("t5");
    pulse_work(32'hFFFFFFFF);
    inc_vrn_flg = 1'b1;
    tick();
    tick();
    check("t5_wrap", version_out, 32'h00000000);
    inc_vrn_flg = 1'b0;
    pulse_work(32'h0);
    inc_vrn_flg = 1'b1;
    pulse_work(32'h12345678);
    check("t5_same_ver", version_out, 32'h12345678);
    tick();
    check("t5_same_inc", version_out, 32'h12345679);
    check("t5_same_req", roll_req, 1);

    // Watchdog, then reset in the middle of a roll with entries queued.
    inc_vrn_flg = 1'b0;
    do_reset("t6");
    for (int k = 1; k <= STALE_LIMIT; k++) begin
      tick();
      check("t6_stale", stale, (k == STALE_LIMIT));
    end
    pulse_work(32'h0000ABCD);
    check("t6_stale_clr", stale, 0);
    for (int i = 1; i <= 3; i++) begin
      blk_fnd = 3'(i);
      tick();
    end
    inc_vrn_flg = 1'b1;
    tick();
    check("t6_cnt_pre", fifo_cnt, 3);
    #3;
    do_reset("t6_mid");
    inc_vrn_flg = 1'b0;
    blk_fnd = 3'd0;
    tick();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) blk_fnd = 3'($urandom);
      if ($urandom_range(15) == 0) inc_vrn_flg = ~inc_vrn_flg;
      work_ld    = ($urandom_range(9) == 0);
      version_in = ($urandom_range(3) == 0) ? 32'hFFFFFFFF : $urandom;
      rd_rdy     = $urandom_range(1);
      crnt_nonce = $urandom;
      cr_tme     = $urandom;
      tick();
    end
    work_ld = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
